// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder: access size codes,
// FSM state encoding and the size/alignment legality rule.
package data_mem_responder_pkg;

   localparam logic [1:0] SIZE_WORD    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_BYTE    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // True when the size code is reserved or the byte lane breaks natural alignment.
   function automatic logic size_lane_illegal(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_WORD:    bad = (lane != 2'b00);
         SIZE_HALF:    bad = lane[0];
         SIZE_BYTE:    bad = 1'b0;
         SIZE_ILLEGAL: bad = 1'b1;
         default:      bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the
// data memory responder (slave).
interface data_mem_responder_if;

   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic        ReqSigned;
   logic [31:0] ReqAddress;
   logic [31:0] ReqWriteData;
   logic        RespValid;
   logic        RespReady;
   logic [31:0] RespReadData;
   logic        RespError;

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWriteData, RespReady,
      input  ReqReady, RespValid, RespReadData, RespError
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWriteData, RespReady,
      output ReqReady, RespValid, RespReadData, RespError
   );

endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// Little-endian lane steering: merges store data into the old word and extracts
// plus sign/zero-extends load data. Purely combinational.
module mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_store_data,
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_signed,
   output logic [31:0] o_new_word,
   output logic [31:0] o_load_data
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       w_lane_en;
         logic [7:0] w_lane_byte;

         // Store data is right-justified, so each lane picks its byte by size.
         always_comb begin
            w_lane_en   = 1'b0;
            w_lane_byte = i_store_data[7:0];
            case (i_size)
               SIZE_WORD: begin
                  w_lane_en   = 1'b1;
                  w_lane_byte = i_store_data[8*gi +: 8];
               end
               SIZE_HALF: begin
                  w_lane_en   = (i_lane[1] == LANE[1]);
                  w_lane_byte = LANE[0] ? i_store_data[15:8] : i_store_data[7:0];
               end
               SIZE_BYTE: begin
                  w_lane_en   = (i_lane == LANE);
               end
               default: ;
            endcase
         end

         assign o_new_word[8*gi +: 8] = w_lane_en ? w_lane_byte : i_word[8*gi +: 8];
      end
   endgenerate

   assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];
   assign w_byte = i_word[{i_lane, 3'b000} +: 8];

   always_comb begin
      o_load_data = i_word;
      case (i_size)
         SIZE_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
         SIZE_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
         default:   o_load_data = i_word;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder for a stall-capable MEM stage: one request in
// flight, IDLE -> ACCESS -> RESP, word/half/byte loads and stores.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
)(
   input  logic                 Clk,
   input  logic                 Rst,
   data_mem_responder_if.slave  bus
);

   localparam int     IDX_W           = $clog2(DEPTH_WORDS);
   localparam state_e ST_AFTER_ACCEPT = (WAIT_CYCLES == 0) ? ST_RESP : ST_ACCESS;

   state_e r_state;
   state_e w_state_next;

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;
   logic        r_err;

   logic             w_req_ready;
   logic             w_resp_valid;
   logic             w_accept;
   logic             w_do_access;
   logic             w_access_done;
   logic             w_op_write;
   logic [1:0]       w_op_size;
   logic             w_op_signed;
   logic [31:0]      w_op_addr;
   logic [31:0]      w_op_wdata;
   logic [IDX_W-1:0] w_idx;
   logic             w_err;
   logic [31:0]      w_old_word;
   logic [31:0]      w_new_word;
   logic [31:0]      w_load_data;

   assign w_accept = w_req_ready & bus.ReqValid;

   generate
      if (WAIT_CYCLES == 0) begin : g_nowait
         // Zero wait states: the access happens on the accept edge from the live request.
         assign w_op_write    = bus.ReqWrite;
         assign w_op_size     = bus.ReqSize;
         assign w_op_signed   = bus.ReqSigned;
         assign w_op_addr     = bus.ReqAddress;
         assign w_op_wdata    = bus.ReqWriteData;
         assign w_access_done = 1'b0;
         assign w_do_access   = w_accept;
      end else begin : g_wait
         localparam int               CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
         localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

         logic [CNT_W-1:0] r_cnt;
         logic             r_write;
         logic [1:0]       r_size;
         logic             r_signed;
         logic [31:0]      r_addr;
         logic [31:0]      r_wdata;

         always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
               r_cnt    <= '0;
               r_write  <= 1'b0;
               r_size   <= SIZE_WORD;
               r_signed <= 1'b0;
               r_addr   <= '0;
               r_wdata  <= '0;
            end else if (w_accept) begin
               r_cnt    <= CNT_LOAD;
               r_write  <= bus.ReqWrite;
               r_size   <= bus.ReqSize;
               r_signed <= bus.ReqSigned;
               r_addr   <= bus.ReqAddress;
               r_wdata  <= bus.ReqWriteData;
            end else if (r_state == ST_ACCESS) begin
               r_cnt    <= r_cnt - CNT_ONE;
            end
         end

         assign w_op_write    = r_write;
         assign w_op_size     = r_size;
         assign w_op_signed   = r_signed;
         assign w_op_addr     = r_addr;
         assign w_op_wdata    = r_wdata;
         assign w_access_done = (r_state == ST_ACCESS) && (r_cnt == CNT_ONE);
         assign w_do_access   = w_access_done;
      end
   endgenerate

   assign w_idx      = w_op_addr[IDX_W+1:2];
   assign w_err      = size_lane_illegal(w_op_size, w_op_addr[1:0]) | (|w_op_addr[31:IDX_W+2]);
   assign w_old_word = r_mem[w_idx];

   mem_lane_align u_lane_align (
      .i_word       (w_old_word),
      .i_store_data (w_op_wdata),
      .i_size       (w_op_size),
      .i_lane       (w_op_addr[1:0]),
      .i_signed     (w_op_signed),
      .o_new_word   (w_new_word),
      .o_load_data  (w_load_data)
   );

   // Storage is not reset; a reset while in ACCESS leaves r_state idle, so no write lands.
   always_ff @(posedge Clk) begin
      if (w_do_access && w_op_write && !w_err) begin
         r_mem[w_idx] <= w_new_word;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_do_access) begin
         r_err   <= w_err;
         r_rdata <= (w_op_write || w_err) ? 32'd0 : w_load_data;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = Rst;
            if (bus.ReqValid && Rst) begin
               w_state_next = ST_AFTER_ACCEPT;
            end
         end
         ST_ACCESS: begin
            if (w_access_done) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_resp_valid = 1'b1;
            if (bus.RespReady) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign bus.ReqReady     = w_req_ready;
   assign bus.RespValid    = w_resp_valid;
   assign bus.RespReadData = r_rdata;
   assign bus.RespError    = r_err;

endmodule
